// File: rtl/div_stall_unit_pkg.sv
// Shared constants and FSM encoding for the EX-stage divider and its stall handshake.
// Stall bus layout matches CTRL; bit STALL_EX is the EX hold.
package div_stall_unit_pkg;

    localparam int STALL_BUS = 6;
    localparam int STALL_EX  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_stall_unit_div_step.sv
// One combinational restoring-division iteration on magnitudes.
// Shifts {rem, quo} left by one and subtracts the divisor when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;
    logic           fits;

    // rem < divisor always holds, so trial < 2*divisor and the top bit of diff is a clean sign.
    always_comb begin
        trial    = {rem, quo[WIDTH-1]};
        diff     = trial - {1'b0, divisor};
        fits     = ~diff[WIDTH];
        rem_next = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div_stall_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in EX; raises a stall request
// while busy and holds its result until EX is released.
module div_stall_unit
    import div_stall_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int STALL_W = STALL_BUS
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [STALL_W-1:0] stall,
    input  logic               div_en,
    input  logic               div_signed,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    output logic               stallreq_for_ex,
    output logic               result_valid,
    output logic [WIDTH-1:0]   result_lo,
    output logic [WIDTH-1:0]   result_hi
);

    localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

    div_state_e       state;
    div_state_e       state_next;
    logic [5:0]       cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic             sign_q;
    logic             sign_r;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             a_neg;
    logic             b_neg;
    logic             ex_hold;
    logic             unused_stall;

    assign ex_hold      = stall[STALL_EX];
    assign unused_stall = ^{stall[STALL_W-1:STALL_EX+1], stall[STALL_EX-1:0]};

    assign a_neg = div_signed & src_a[WIDTH-1];
    assign b_neg = div_signed & src_b[WIDTH-1];
    assign a_mag = a_neg ? -src_a : src_a;
    assign b_mag = b_neg ? -src_b : src_b;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // Gated by resetn so the request drops the instant reset asserts, not at the next edge.
    assign stallreq_for_ex = resetn & div_en & (state != DONE);
    assign result_valid    = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (div_en) begin
                    state_next = (src_b == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (!div_en) begin
                    state_next = IDLE;
                end else if (cnt == LAST_STEP) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!div_en || !ex_hold) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result registers load only on entry to DONE, so a cancelled divide leaves them untouched.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            divisor   <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (div_en) begin
                        rem     <= '0;
                        quo     <= a_mag;
                        divisor <= b_mag;
                        sign_q  <= a_neg ^ b_neg;
                        sign_r  <= a_neg;
                        cnt     <= '0;
                        if (src_b == '0) begin
                            result_lo <= '1;
                            result_hi <= src_a;
                        end
                    end
                end
                CALC: begin
                    if (div_en) begin
                        rem <= rem_next;
                        quo <= quo_next;
                        cnt <= cnt + 6'd1;
                        if (cnt == LAST_STEP) begin
                            result_lo <= sign_q ? -quo_next : quo_next;
                            result_hi <= sign_r ? -rem_next : rem_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_stall_unit.sv
// Scoreboard bench for div_stall_unit: stimulus pushes expected {hi, lo}, a monitor
// compares whenever result_valid is up and retires the entry when EX is released.
module tb_div_stall_unit;
    import div_stall_unit_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [5:0]  stall;
    logic        div_en = 1'b0;
    logic        div_signed = 1'b0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        stallreq_for_ex;
    logic        result_valid;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        force_hold = 1'b0;

    int          n_vec = 0;
    int          n_miss = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    // CTRL model: answers a stall request with 001111; force_hold adds an extra EX hold.
    assign stall = (stallreq_for_ex ? 6'b001111 : 6'b000000) | (force_hold ? 6'b001000 : 6'b000000);

    div_stall_unit #(
        .WIDTH   (32),
        .STALL_W (6)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .stall           (stall),
        .div_en          (div_en),
        .div_signed      (div_signed),
        .src_a           (src_a),
        .src_b           (src_b),
        .stallreq_for_ex (stallreq_for_ex),
        .result_valid    (result_valid),
        .result_lo       (result_lo),
        .result_hi       (result_hi)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: plain magnitude division, then sign the results; returns {hi, lo}.
    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb, q, r;
        bit          na, nb;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        na = sgn && a[31];
        nb = sgn && b[31];
        ma = na ? (32'd0 - a) : a;
        mb = nb ? (32'd0 - b) : b;
        q  = ma / mb;
        r  = ma % mb;
        if (na ^ nb) q = 32'd0 - q;
        if (na) r = 32'd0 - r;
        return {r, q};
    endfunction

    task automatic apply_stimulus(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  input int hold, input bit drop);
        int sreq;
        int cycles;
        exp_q.push_back(model(sgn, a, b));
        div_en     = 1'b1;
        div_signed = sgn;
        src_a      = a;
        src_b      = b;
        #1;
        sreq   = stallreq_for_ex ? 1 : 0;
        cycles = 0;
        while (cycles <= 100) begin
            @(negedge clk);
            if (result_valid) break;
            if (stallreq_for_ex) sreq++;
            cycles++;
        end
        check_output("stallreq_cycles", 32'(sreq), (b == 32'd0) ? 32'd1 : 32'd33);
        check_output("valid_reached", {31'd0, result_valid}, 32'd1);
        check_output("stallreq_in_done", {31'd0, stallreq_for_ex}, 32'd0);
        #1;
        if (hold > 0) begin
            force_hold = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check_output("held_valid", {31'd0, result_valid}, 32'd1);
                check_output("held_stallreq", {31'd0, stallreq_for_ex}, 32'd0);
            end
            #1;
            force_hold = 1'b0;
        end
        if (drop) begin
            div_en = 1'b0;
            src_a  = $urandom;
            src_b  = $urandom;
        end
    endtask

    // Monitor: compare every valid cycle, retire the entry when EX is not held this cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn && result_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("[TB] FAIL unexpected_valid: got lo=%h hi=%h, expected no result", result_lo, result_hi);
                end else begin
                    check_output("result_lo", result_lo, exp_q[0][31:0]);
                    check_output("result_hi", result_hi, exp_q[0][63:32]);
                    #4;
                    if (!stall[STALL_EX]) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] a, b;
        bit          sgn;
        div_en = 1'b1;
        src_a  = 32'd50;
        src_b  = 32'd5;
        #1;
        check_output("reset_stallreq", {31'd0, stallreq_for_ex}, 32'd0);
        check_output("reset_valid", {31'd0, result_valid}, 32'd0);
        check_output("reset_lo", result_lo, 32'd0);
        check_output("reset_hi", result_hi, 32'd0);
        div_en = 1'b0;
        repeat (3) @(negedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        #1;

        apply_stimulus(1'b0, 32'd100, 32'd7, 0, 1'b1);
        apply_stimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b1);
        apply_stimulus(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 1'b1);
        apply_stimulus(1'b0, 32'd5, 32'd0, 0, 1'b1);
        apply_stimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1);
        apply_stimulus(1'b0, 32'd1000, 32'd3, 4, 1'b1);

        // Cancel at cnt=10, then re-issue.
        div_en = 1'b1; div_signed = 1'b0; src_a = 32'd100; src_b = 32'd7;
        repeat (11) @(negedge clk);
        #1 div_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_output("cancel_valid", {31'd0, result_valid}, 32'd0);
        end
        #1;
        apply_stimulus(1'b0, 32'd9, 32'd3, 0, 1'b1);

        // Reset mid-CALC at cnt=20.
        @(negedge clk);
        #1 div_en = 1'b1; div_signed = 1'b0; src_a = 32'hDEAD_BEEF; src_b = 32'd13;
        repeat (21) @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        check_output("midreset_stallreq", {31'd0, stallreq_for_ex}, 32'd0);
        check_output("midreset_valid", {31'd0, result_valid}, 32'd0);
        check_output("midreset_lo", result_lo, 32'd0);
        check_output("midreset_hi", result_hi, 32'd0);
        div_en = 1'b0;
        @(negedge clk);
        #1 resetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_output("postreset_valid", {31'd0, result_valid}, 32'd0);
        end
        #1;
        apply_stimulus(1'b0, 32'd1, 32'd1, 0, 1'b1);

        // Back-to-back with div_en held across the retire.
        apply_stimulus(1'b0, 32'd20, 32'd6, 0, 1'b0);
        apply_stimulus(1'b0, 32'd9, 32'd4, 0, 1'b1);

        for (int i = 0; i < 24; i++) begin
            sgn = 1'($urandom % 2);
            a   = $urandom;
            case ($urandom % 5)
                0: b = 32'd0;
                1: b = $urandom % 16;
                2: b = sgn ? 32'hFFFF_FFFF : 32'd1;
                3: b = 32'd0 - ($urandom % 100);
                default: b = $urandom;
            endcase
            apply_stimulus(sgn, a, b, ($urandom % 4 == 0) ? 2 : 0, 1'($urandom % 2) || (i == 23));
        end

        repeat (4) @(negedge clk);
        check_output("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
